// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR job scheduler.
// Job descriptor layout, LSB first:
//   in_addr [ADDR_W], out_addr [ADDR_W], count [ADDR_W], pipelined [1]
// The job FIFO stores {tag[1:0], descriptor}.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_REPORT
    } sched_state_t;

    function automatic int unsigned desc_w(input int unsigned aw);
        return 3 * aw + 1;
    endfunction

    function automatic int unsigned off_in(input int unsigned aw);
        return 0 * aw;
    endfunction

    function automatic int unsigned off_out(input int unsigned aw);
        return aw;
    endfunction

    function automatic int unsigned off_cnt(input int unsigned aw);
        return 2 * aw;
    endfunction

    function automatic int unsigned off_pip(input int unsigned aw);
        return 3 * aw;
    endfunction

endpackage

// File: rtl/fir_job_scheduler_if.sv
// Bus bundle for fir_job_scheduler: job intake channel, FIR core control
// channel and result channel.
//   master : host/bench side (offers jobs, models the core, consumes results)
//   slave  : scheduler side
interface fir_job_scheduler_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 32
) ();
    logic              job_valid;
    logic              job_ready;
    logic [ADDR_W-1:0] job_in_addr;
    logic [ADDR_W-1:0] job_out_addr;
    logic [ADDR_W-1:0] job_count;
    logic              job_pipelined;

    logic              fir_start;
    logic              fir_sel_pipelined;
    logic [ADDR_W-1:0] fir_input_addr;
    logic [ADDR_W-1:0] fir_output_addr;
    logic [ADDR_W-1:0] fir_sample_count;
    logic              fir_done;

    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_tag;
    logic [CNT_W-1:0]  res_cycles;
    logic              res_timeout;

    modport master (
        output job_valid, job_in_addr, job_out_addr, job_count, job_pipelined,
        output fir_done, res_ready,
        input  job_ready, fir_start, fir_sel_pipelined, fir_input_addr,
        input  fir_output_addr, fir_sample_count,
        input  res_valid, res_tag, res_cycles, res_timeout
    );

    modport slave (
        input  job_valid, job_in_addr, job_out_addr, job_count, job_pipelined,
        input  fir_done, res_ready,
        output job_ready, fir_start, fir_sel_pipelined, fir_input_addr,
        output fir_output_addr, fir_sample_count,
        output res_valid, res_tag, res_cycles, res_timeout
    );
endinterface

// File: rtl/fir_job_fifo.sv
// Synchronous FIFO for tagged job descriptors. No bypass: data pushed in
// one cycle is visible on dout from the next cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, din     write strobe and data (ignored when full)
//   pop, dout     read strobe (ignored when empty), head-of-queue data
//   full, empty   occupancy flags
module fir_job_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fir_job_scheduler.sv
// FIR job scheduler: queues job descriptors, launches them one at a time on
// the shared FIR core, measures cycles per job and returns a tagged result.
// Optional feature: define FIR_SCHED_TIMEOUT_EN to enable the RUN watchdog
// (aborts after TIMEOUT_CYCLES and reports res_timeout=1).
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       slave side of fir_job_scheduler_if (job / core / result)
//   busy      FSM not idle or jobs still queued
module fir_job_scheduler
    import fir_sched_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned QDEPTH         = 4,
    parameter int unsigned START_CYCLES   = 10,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_job_scheduler_if.slave   bus,
    output logic                 busy
);
    localparam int unsigned DW     = desc_w(ADDR_W);
    localparam int unsigned FW     = DW + 2;
    localparam int unsigned O_IN   = off_in(ADDR_W);
    localparam int unsigned O_OUT  = off_out(ADDR_W);
    localparam int unsigned O_CNT  = off_cnt(ADDR_W);
    localparam int unsigned O_PIP  = off_pip(ADDR_W);
    localparam int unsigned LCNT_W = $clog2(START_CYCLES + 1);
`ifdef FIR_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    sched_state_t      state, state_nxt;
    logic [FW-1:0]     push_data, pop_data;
    logic              push, pop, full, empty;
    logic [1:0]        tag_cnt;
    logic [LCNT_W-1:0] lcnt;
    logic [CNT_W-1:0]  cyc, cyc_inc;
    logic              timeout_hit;
    logic [ADDR_W-1:0] pop_cnt;
    logic [ADDR_W-1:0] in_q, out_q, cnt_q;
    logic              pip_q, to_q;
    logic [1:0]        tag_q;

    assign push      = bus.job_valid && bus.job_ready;
    assign push_data = {tag_cnt, bus.job_pipelined, bus.job_count,
                        bus.job_out_addr, bus.job_in_addr};
    assign pop_cnt   = pop_data[O_CNT +: ADDR_W];

    fir_job_fifo #(
        .WIDTH (FW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (pop_data),
        .full  (full),
        .empty (empty)
    );

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    assign cyc_inc     = (&cyc) ? cyc : cyc + CNT_W'(1);
    assign timeout_hit = TO_EN && (state == S_RUN) &&
                         (cyc == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = (pop_cnt == '0) ? S_REPORT : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (lcnt == LCNT_W'(START_CYCLES - 1)) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (timeout_hit || bus.fir_done) state_nxt = S_REPORT;
            end
            S_REPORT: begin
                if (bus.res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tag_cnt <= '0;
            lcnt    <= '0;
            cyc     <= '0;
            in_q    <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            pip_q   <= 1'b0;
            tag_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) tag_cnt <= tag_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tag_q <= pop_data[DW +: 2];
                        to_q  <= 1'b0;
                        lcnt  <= '0;
                        cyc   <= '0;
                        // Zero-length jobs skip the core, so the core
                        // configuration stays on the previous job.
                        if (pop_cnt != '0) begin
                            in_q  <= pop_data[O_IN +: ADDR_W];
                            out_q <= pop_data[O_OUT +: ADDR_W];
                            cnt_q <= pop_cnt;
                            pip_q <= pop_data[O_PIP];
                        end
                    end
                end
                S_LAUNCH: begin
                    lcnt <= lcnt + 1'b1;
                    cyc  <= cyc_inc;
                end
                S_RUN: begin
                    if (timeout_hit) to_q <= 1'b1;
                    else             cyc  <= cyc_inc;
                end
                default: ;
            endcase
        end
    end

    // job_ready is gated by rst so every output reads 0 while reset is held.
    assign bus.job_ready         = !full && !rst;
    assign bus.fir_start         = (state == S_LAUNCH);
    assign bus.fir_sel_pipelined = pip_q;
    assign bus.fir_input_addr    = in_q;
    assign bus.fir_output_addr   = out_q;
    assign bus.fir_sample_count  = cnt_q;
    assign bus.res_valid         = (state == S_REPORT);
    assign bus.res_tag           = tag_q;
    assign bus.res_cycles        = cyc;
    assign bus.res_timeout       = to_q;
    assign busy                  = (state != S_IDLE) || !empty;
endmodule

// File: tb/tb_fir_job_scheduler.sv
module tb_fir_job_scheduler;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned START  = 10;
`ifdef FIR_SCHED_TIMEOUT_EN
    localparam int unsigned TO_CYC = 64;
`else
    localparam int unsigned TO_CYC = 4096;
`endif

    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    fir_job_scheduler_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    fir_job_scheduler #(
        .ADDR_W         (ADDR_W),
        .QDEPTH         (4),
        .START_CYCLES   (START),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Expected tags of accepted jobs, in acceptance order.
    logic [1:0] tag_q[$];
    logic [1:0] next_tag;

    // Core model: done rises core_delay cycles after fir_start falls.
    bit core_stall;
    int core_delay;
    int start_seen;
    bit armed;
    int run_cnt;

    initial begin
        bus.fir_done = 1'b0;
        armed        = 1'b0;
        run_cnt      = 0;
        start_seen   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.fir_done = 1'b0;
                armed        = 1'b0;
            end else if (bus.fir_start) begin
                bus.fir_done = 1'b0;
                armed        = 1'b1;
                run_cnt      = 0;
                start_seen++;
            end else if (armed) begin
                run_cnt++;
                if (!core_stall && run_cnt == core_delay) begin
                    bus.fir_done = 1'b1;
                    armed        = 1'b0;
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge after the accepting edge.
    task automatic push_job(input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] oa,
                            input logic [ADDR_W-1:0] cnt, input logic pip);
        bit ok = 1'b0;
        int i  = 0;
        bus.job_in_addr   = ia;
        bus.job_out_addr  = oa;
        bus.job_count     = cnt;
        bus.job_pipelined = pip;
        bus.job_valid     = 1'b1;
        while (!ok && i < 200) begin
            if (bus.job_ready) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
                i++;
            end
        end
        bus.job_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL push_accept: accepted=%0d required=1", ok);
        end else begin
            tag_q.push_back(next_tag);
            next_tag = next_tag + 2'd1;
        end
    endtask

    // Waits (bounded) for res_valid, captures the result, then handshakes it.
    task automatic get_result(input int budget, output logic [1:0] tag,
                              output logic [CNT_W-1:0] cyc, output logic to,
                              output int waited);
        waited = 0;
        tag    = 'x;
        cyc    = 'x;
        to     = 1'bx;
        while (!bus.res_valid && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!bus.res_valid) begin
            failures++;
            $display("FAIL result_wait: res_valid=0 after %0d cycles required=1", waited);
        end else begin
            tag           = bus.res_tag;
            cyc           = bus.res_cycles;
            to            = bus.res_timeout;
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.job_valid = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        tag_q.delete();
        next_tag = 2'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.fir_start, bus.res_valid, busy, bus.job_ready, bus.res_timeout} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: start/valid/busy/ready/to=%b required=00000",
                     {bus.fir_start, bus.res_valid, busy, bus.job_ready, bus.res_timeout});
        end
        checks++;
        if (bus.res_cycles !== '0 || bus.res_tag !== 2'd0 || bus.fir_sample_count !== '0) begin
            failures++;
            $display("FAIL reset_data: cycles=%0d tag=%0d count=%0d required 0/0/0",
                     bus.res_cycles, bus.res_tag, bus.fir_sample_count);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.job_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: job_ready=%b required=1", bus.job_ready);
        end
    endtask

    task automatic test_single();
        logic [1:0]       tag;
        logic [CNT_W-1:0] cyc;
        logic             to;
        int               w;
        int               s0 = start_seen;
        int               i  = 0;
        core_stall = 1'b0;
        core_delay = 150;
        push_job(10'd0, 10'd32, 10'd20, 1'b0);
        while (!bus.fir_start && i < 10) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (bus.fir_input_addr !== 10'd0 || bus.fir_output_addr !== 10'd32 ||
            bus.fir_sample_count !== 10'd20 || bus.fir_sel_pipelined !== 1'b0) begin
            failures++;
            $display("FAIL single_cfg: in=%0d out=%0d cnt=%0d sel=%b required 0/32/20/0",
                     bus.fir_input_addr, bus.fir_output_addr, bus.fir_sample_count,
                     bus.fir_sel_pipelined);
        end
        get_result(400, tag, cyc, to, w);
        checks++;
        if (start_seen - s0 !== 10) begin
            failures++;
            $display("FAIL single_start_len: start_cycles=%0d required=10", start_seen - s0);
        end
        checks++;
        if (cyc !== 32'd160) begin
            failures++;
            $display("FAIL single_cycles: res_cycles=%0d required=160", cyc);
        end
        checks++;
        if (tag !== 2'd0 || to !== 1'b0) begin
            failures++;
            $display("FAIL single_tag: tag=%0d timeout=%b required 0/0", tag, to);
        end
        void'(tag_q.pop_front());
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: busy=%b required=0", busy);
        end
    endtask

    task automatic test_zero_count();
        logic [1:0]       tag;
        logic [CNT_W-1:0] cyc;
        logic             to;
        int               w;
        logic [1:0]       et;
        int               s0 = start_seen;
        push_job(10'd5, 10'd6, 10'd0, 1'b1);
        et = tag_q[0];
        get_result(5, tag, cyc, to, w);
        void'(tag_q.pop_front());
        checks++;
        if (w > 2) begin
            failures++;
            $display("FAIL zero_latency: wait=%0d required<=2", w);
        end
        checks++;
        if (cyc !== '0 || tag !== et) begin
            failures++;
            $display("FAIL zero_result: cycles=%0d tag=%0d required 0/%0d", cyc, tag, et);
        end
        checks++;
        if (start_seen !== s0 || bus.fir_sample_count !== 10'd20 || bus.fir_sel_pipelined !== 1'b0) begin
            failures++;
            $display("FAIL zero_no_core: starts=%0d cnt=%0d sel=%b required 0/20/0",
                     start_seen - s0, bus.fir_sample_count, bus.fir_sel_pipelined);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]       tag;
        logic [CNT_W-1:0] cyc;
        logic             to;
        int               w;
        logic [1:0]       et;
        core_stall = 1'b0;
        core_delay = 3;
        // A zero-length job parked in REPORT holds off the FSM so the FIFO fills.
        push_job(10'd0, 10'd0, 10'd0, 1'b0);
        for (int k = 1; k <= 4; k++) push_job(10'(k * 16), 10'(k * 16 + 8), 10'd8, 1'b1);
        checks++;
        if (bus.job_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full: job_ready=%b busy=%b required 0/1", bus.job_ready, busy);
        end
        et = tag_q.pop_front();
        get_result(5, tag, cyc, to, w);
        checks++;
        if (tag !== et) begin
            failures++;
            $display("FAIL b2b_park_tag: tag=%0d required=%0d", tag, et);
        end
        push_job(10'd80, 10'd88, 10'd8, 1'b1);
        for (int k = 0; k < 5; k++) begin
            et = tag_q.pop_front();
            get_result(100, tag, cyc, to, w);
            checks++;
            if (tag !== et || cyc !== 32'd13) begin
                failures++;
                $display("FAIL b2b_result%0d: tag=%0d cycles=%0d required %0d/13", k, tag, cyc, et);
            end
        end
    endtask

    task automatic test_res_stall();
        logic [1:0]       tag, t0;
        logic [CNT_W-1:0] cyc, c0;
        logic             to;
        int               w;
        int               s0;
        int               bad = 0;
        int               i   = 0;
        logic [1:0]       et;
        core_stall = 1'b0;
        core_delay = 3;
        push_job(10'd1, 10'd2, 10'd7, 1'b1);
        push_job(10'd3, 10'd4, 10'd9, 1'b0);
        while (!bus.res_valid && i < 100) begin
            @(negedge clk);
            i++;
        end
        t0 = bus.res_tag;
        c0 = bus.res_cycles;
        s0 = start_seen;
        checks++;
        if (bus.fir_sel_pipelined !== 1'b1 || bus.fir_sample_count !== 10'd7) begin
            failures++;
            $display("FAIL stall_cfg: sel=%b cnt=%0d required 1/7",
                     bus.fir_sel_pipelined, bus.fir_sample_count);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_tag !== t0 || bus.res_cycles !== c0 ||
                bus.fir_start !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || start_seen !== s0) begin
            failures++;
            $display("FAIL stall_hold: unstable_cycles=%0d starts=%0d required 0/0",
                     bad, start_seen - s0);
        end
        et = tag_q.pop_front();
        get_result(5, tag, cyc, to, w);
        checks++;
        if (tag !== et || cyc !== 32'd13) begin
            failures++;
            $display("FAIL stall_first: tag=%0d cycles=%0d required %0d/13", tag, cyc, et);
        end
        et = tag_q.pop_front();
        get_result(100, tag, cyc, to, w);
        checks++;
        if (tag !== et || cyc !== 32'd13 || bus.fir_sel_pipelined !== 1'b0 ||
            bus.fir_sample_count !== 10'd9) begin
            failures++;
            $display("FAIL stall_second: tag=%0d cycles=%0d sel=%b cnt=%0d required %0d/13/0/9",
                     tag, cyc, bus.fir_sel_pipelined, bus.fir_sample_count, et);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [1:0]       tag;
        logic [CNT_W-1:0] cyc;
        logic             to;
        int               w;
        int               i    = 0;
        int               seen = 0;
        core_stall = 1'b1;
        push_job(10'd100, 10'd200, 10'd30, 1'b1);
        push_job(10'd1, 10'd1, 10'd5, 1'b0);
        push_job(10'd2, 10'd2, 10'd5, 1'b0);
        while (!(bus.fir_input_addr == 10'd100 && !bus.fir_start) && i < 50) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus.fir_input_addr !== 10'd100) begin
            failures++;
            $display("FAIL rst_pre: busy=%b in=%0d required 1/100", busy, bus.fir_input_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.fir_start, bus.fir_sel_pipelined, bus.res_valid, bus.res_timeout,
             bus.job_ready, busy} !== 6'b0 ||
            {bus.fir_input_addr, bus.fir_output_addr, bus.fir_sample_count} !== '0 ||
            bus.res_cycles !== '0 || bus.res_tag !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: start=%b sel=%b valid=%b busy=%b in=%0d cyc=%0d required all 0",
                     bus.fir_start, bus.fir_sel_pipelined, bus.res_valid, busy,
                     bus.fir_input_addr, bus.res_cycles);
        end
        rst = 1'b0;
        tag_q.delete();
        next_tag = 2'd0;
        core_stall = 1'b0;
        core_delay = 2;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.res_valid || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_flush: active_cycles=%0d required=0", seen);
        end
        push_job(10'd9, 10'd9, 10'd3, 1'b0);
        void'(tag_q.pop_front());
        get_result(100, tag, cyc, to, w);
        checks++;
        if (tag !== 2'd0 || cyc !== 32'd12) begin
            failures++;
            $display("FAIL rst_tag_restart: tag=%0d cycles=%0d required 0/12", tag, cyc);
        end
    endtask

`ifdef FIR_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        logic [1:0]       tag;
        logic [CNT_W-1:0] cyc;
        logic             to;
        int               w;
        logic [1:0]       et;
        core_stall = 1'b1;
        push_job(10'd7, 10'd8, 10'd4, 1'b0);
        et = tag_q.pop_front();
        get_result(300, tag, cyc, to, w);
        checks++;
        if (to !== 1'b1 || cyc !== 32'd64 || tag !== et) begin
            failures++;
            $display("FAIL timeout_abort: to=%b cycles=%0d tag=%0d required 1/64/%0d", to, cyc, tag, et);
        end
        core_stall = 1'b0;
        core_delay = 5;
        push_job(10'd7, 10'd8, 10'd4, 1'b0);
        et = tag_q.pop_front();
        get_result(300, tag, cyc, to, w);
        checks++;
        if (to !== 1'b0 || cyc !== 32'd15 || tag !== et) begin
            failures++;
            $display("FAIL timeout_recover: to=%b cycles=%0d tag=%0d required 0/15/%0d", to, cyc, tag, et);
        end
    endtask
`endif

    initial begin
        rst               = 1'b1;
        bus.job_valid     = 1'b0;
        bus.job_in_addr   = '0;
        bus.job_out_addr  = '0;
        bus.job_count     = '0;
        bus.job_pipelined = 1'b0;
        bus.res_ready     = 1'b0;
        core_stall        = 1'b0;
        core_delay        = 1;
        next_tag          = 2'd0;
        @(negedge clk);
        test_reset();
        test_single();
        test_zero_count();
        test_back_to_back();
        test_res_stall();
        test_reset_mid_run();
`ifdef FIR_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
